// File: rtl/mic_sum_pkg.sv
// Shared constants and helpers for the time-multiplexed mic frame summer.
// Optional per-channel masking is enabled by defining MIC_SUM_CHAN_MASK_EN.
package mic_sum_pkg;

  localparam int N_CH_DEF = 16;
  localparam int IN_W_DEF = 19;

  function automatic int out_w_def(input int in_w, input int n_ch);
    return in_w + $clog2(n_ch);
  endfunction

  // Sign-extend the low w bits of x to 32 bits; callers truncate to OUT_W.
  function automatic logic [31:0] sext_to_out(input logic [31:0] x,
                                               input int w);
    logic signed [31:0] t;
    t = signed'(x << (32 - w));
    return 32'(t >>> (32 - w));
  endfunction

endpackage

// File: rtl/mic_sum_acc_dp.sv
// Accumulator datapath: one shared adder feeding the frame accumulator.
// clr has priority over load, load over add.
module mic_sum_acc_dp #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         add_en,
  input  logic         load_en,
  input  logic         clr,
  input  logic [W-1:0] sample,
  output logic [W-1:0] sum_next
);

  logic [W-1:0] acc;

  assign sum_next = acc + sample;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (load_en) begin
      acc <= sample;
    end else if (add_en) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/mic_sum_sequencer.sv
// Serial N_CH-channel mic frame summer with valid/ready in and out.
// Define MIC_SUM_CHAN_MASK_EN to add chan_mask and out_nact ports.
module mic_sum_sequencer
  import mic_sum_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int IN_W  = IN_W_DEF,
  localparam int OUT_W = out_w_def(IN_W, N_CH),
  localparam int CW    = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_sample,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef MIC_SUM_CHAN_MASK_EN
  input  logic [N_CH-1:0]  chan_mask,
  output logic [CW:0]      out_nact,
`endif
  output logic [OUT_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err
);

  logic [CW-1:0]    ch_cnt;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] addend;
  logic [OUT_W-1:0] sum_next;
  logic             accept;
  logic             first;
  logic             last;
  logic             start;
  logic             step;
  logic             done;
  logic             early;
  logic             drop;
  logic             active;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (ch_cnt == '0);
  assign last     = (ch_cnt == CW'(N_CH - 1));
  assign busy     = !first;

  // sof always restarts, even on the would-be last sample.
  assign start = accept && in_sof;
  assign early = start && !first;
  assign drop  = accept && !in_sof && first;
  assign step  = accept && !in_sof && !first;
  assign done  = step && last;

  assign ext    = OUT_W'(sext_to_out(32'(in_sample), IN_W));
  assign addend = active ? ext : '0;

`ifdef MIC_SUM_CHAN_MASK_EN
  logic [N_CH-1:0] mask_q;
  logic [CW:0]     nact;

  assign active = in_sof ? chan_mask[0] : mask_q[ch_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      nact     <= '0;
      out_nact <= '0;
    end else begin
      if (start) begin
        mask_q <= chan_mask;
        nact   <= (CW + 1)'(active);
      end else if (done) begin
        nact <= '0;
      end else if (step) begin
        nact <= nact + (CW + 1)'(active);
      end
      if (done) begin
        out_nact <= nact + (CW + 1)'(active);
      end
    end
  end
`else
  assign active = 1'b1;
`endif

  mic_sum_acc_dp #(
    .W(OUT_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .add_en   (step && !last),
    .load_en  (start),
    .clr      (done),
    .sample   (addend),
    .sum_next (sum_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt    <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early || drop;
      if (start) begin
        ch_cnt <= CW'(1);
      end else if (done) begin
        ch_cnt <= '0;
      end else if (step) begin
        ch_cnt <= ch_cnt + CW'(1);
      end
      if (done) begin
        out_sum   <= sum_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic_sum_sequencer.sv
// Self-checking bench for mic_sum_sequencer: frame table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_mic_sum_sequencer;

  localparam int N  = 16;
  localparam int IW = 19;
  localparam int OW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] in_sample = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_sum;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          frame_err;
`ifdef MIC_SUM_CHAN_MASK_EN
  logic [N-1:0]        chan_mask = '1;
  logic [$clog2(N):0]  out_nact;
`endif

  always #5 clk = ~clk;

  mic_sum_sequencer #(
    .N_CH(N),
    .IN_W(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sample (in_sample),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MIC_SUM_CHAN_MASK_EN
    .chan_mask (chan_mask),
    .out_nact  (out_nact),
`endif
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [IW-1:0] sample;
    logic [OW-1:0] sum;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            err_exp = 0;
  int            err_seen = 0;
  int            rdy_pct = 100;
  int            frame_q[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] seen_q[$];
  vec_t          tv[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is the list of samples since the last sof.
  function automatic void model_accept(input logic [IW-1:0] s,
                                       input logic sof);
    int v;
    int sum;
    v = int'($signed(s));
    if (sof) begin
      if (frame_q.size() != 0) err_exp++;
      frame_q.delete();
      frame_q.push_back(v);
    end else if (frame_q.size() == 0) begin
      err_exp++;
    end else begin
      frame_q.push_back(v);
      if (frame_q.size() == N) begin
        sum = 0;
        foreach (frame_q[i]) sum += frame_q[i];
        exp_q.push_back(OW'(sum));
        frame_q.delete();
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = (int'($urandom_range(99)) < rdy_pct);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (out_valid && out_ready) begin
        seen_q.push_back(out_sum);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", out_sum);
        end else if (out_sum !== exp_q[0]) begin
          errors++;
          $display("FAIL model_sum: got %0h expected %0h",
                   out_sum, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IW-1:0] s, input logic sof);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_sample = s;
    in_sof    = sof;
    in_valid  = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (ok) begin
      model_accept(s, sof);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic send_frame(input int v, input int n);
    for (int k = 0; k < n; k++) send(IW'(v), k == 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_pct = 100;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_seen(input int k);
    int n;
    n = 0;
    while (seen_q.size() < k && n < 200) begin
      idle(1);
      n++;
    end
  endtask

  task automatic pop_chk(input string name, input logic [OW-1:0] exp);
    if (seen_q.size() == 0) begin
      chk(name, 32'hDEAD, 32'(exp));
    end else begin
      chk(name, 32'(seen_q.pop_front()), 32'(exp));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    frame_q.delete();
    exp_q.delete();
    seen_q.delete();
  endtask

  initial begin
    int e0;
    logic sof;
    tv[0] = '{19'h00001, 23'h000010};
    tv[1] = '{19'h40000, 23'h400000};
    tv[2] = '{19'h3FFFF, 23'h3FFFF0};
    tv[3] = '{19'h7FFFF, 23'h7FFFF0};
    tv[4] = '{19'h12345, 23'h123450};
    tv[5] = '{19'h00007, 23'h000070};

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      seen_q.delete();
      send(tv[i].sample, 1'b1);
      if (i == 0) chk("busy_mid", 32'(busy), 32'd1);
      for (int k = 1; k < N - 1; k++) send(tv[i].sample, 1'b0);
      if (i == 0) chk("pre_latency", 32'(out_valid), 32'd0);
      send(tv[i].sample, 1'b0);
      if (i == 0) begin
        @(negedge clk);
        chk("latency", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("one_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      wait_seen(1);
      pop_chk("table_sum", tv[i].sum);
    end
    drain();

    // Stalled output backs up the input for five cycles.
    seen_q.delete();
    rdy_pct = 0;
    idle(1);
    send_frame(1, N);
    @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    fork
      begin
        repeat (5) @(posedge clk);
        rdy_pct = 100;
      end
      send_frame(2, N);
    join
    wait_seen(2);
    pop_chk("stall_sum1", 23'd16);
    pop_chk("stall_sum2", 23'd32);
    drain();

    seen_q.delete();
    e0 = err_seen;
    send_frame(5, 7);
    send_frame(3, N);
    drain();
    chk("early_sof_err", 32'(err_seen - e0), 32'd1);
    chk("early_sof_nout", 32'(seen_q.size()), 32'd1);
    pop_chk("early_sof_sum", 23'd48);

    seen_q.delete();
    e0 = err_seen;
    for (int k = 0; k < 3; k++) send(IW'(4), 1'b0);
    send_frame(-1, N);
    drain();
    chk("no_sof_err", 32'(err_seen - e0), 32'd3);
    pop_chk("no_sof_sum", 23'h7FFFF0);

    send_frame(9, 10);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send_frame(7, N);
    drain();
    chk("rst_nout", 32'(seen_q.size()), 32'd1);
    pop_chk("rst_sum", 23'd112);

    rdy_pct = 60;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2)));
      if (frame_q.size() == 0) sof = ($urandom_range(9) != 0);
      else sof = ($urandom_range(29) == 0);
      send(IW'($urandom), sof);
    end
    drain();
    chk("err_count", 32'(err_seen), 32'(err_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
